serial_gteq_comparator: RTL and testbench

//  Sequential, bit-serial counterpart to the combinational GTEQ comparators.
//  - Accepts an operand pair over a valid/ready handshake and scans it MSB-first, one bit per clock.
//  - Stops early at the first differing bit.
//  - Returns GTEQ/GT/EQ over a second valid/ready handshake.
//  - Used where a full N-bit comparator is too large or too slow, e.g. wide operands on narrow datapaths.

---
 rtl/serial_gteq_comparator.sv | 128 ++++++++++++
 tb/tb_serial_gteq_comparator.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_gteq_comparator.sv
// Bit-serial unsigned magnitude comparator: scans an operand pair MSB-first,
// stops at the first differing bit and returns gteq/gt/eq over valid/ready.
module serial_gteq_comparator #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         gteq,
    output logic         gt,
    output logic         eq
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [N-1:0]    r_a_q;
    logic [N-1:0]    r_b_q;
    logic [IW-1:0]   r_idx;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_gteq;
    logic            r_gt;
    logic            r_eq;

    logic            w_accept;
    logic            w_load_res;
    logic            w_dec;
    logic            w_res_gt;
    logic            w_res_eq;
    logic            w_bit_a;
    logic            w_bit_b;

    assign w_bit_a = r_a_q[r_idx];
    assign w_bit_b = r_b_q[r_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load_res   = 1'b0;
        w_dec        = 1'b0;
        w_res_gt     = 1'b0;
        w_res_eq     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = SCAN;
                end
            end
            SCAN: begin
                if (w_bit_a != w_bit_b) begin
                    w_load_res   = 1'b1;
                    w_res_gt     = w_bit_a;
                    w_next_state = DONE;
                end else if (r_idx == '0) begin
                    w_load_res   = 1'b1;
                    w_res_eq     = 1'b1;
                    w_next_state = DONE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs, steered by the FSM strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_q       <= '0;
            r_b_q       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_gteq      <= 1'b0;
            r_gt        <= 1'b0;
            r_eq        <= 1'b0;
        end else begin
            r_in_ready  <= (w_next_state == IDLE);
            r_out_valid <= (w_next_state == DONE);
            if (w_accept) begin
                r_a_q <= a;
                r_b_q <= b;
                r_idx <= IW'(N - 1);
            end else if (w_dec) begin
                r_idx <= r_idx - IW'(1);
            end
            if (w_load_res) begin
                r_gt   <= w_res_gt;
                r_eq   <= w_res_eq;
                r_gteq <= w_res_gt | w_res_eq;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign gteq      = r_gteq;
    assign gt        = r_gt;
    assign eq        = r_eq;

endmodule

// File: tb/tb_serial_gteq_comparator.sv
// Directed bench for serial_gteq_comparator: scoreboarded results, latency,
// backpressure, mid-scan reset and back-to-back operation.
module tb_serial_gteq_comparator;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic         gteq;
    logic         gt;
    logic         eq;

    typedef struct {
        logic        gteq;
        logic        gt;
        logic        eq;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    serial_gteq_comparator #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gteq      (gteq),
        .gt        (gt),
        .eq        (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned compare, latency = N - (highest differing bit), or N if equal
    task automatic push(input logic [N-1:0] ea, input logic [N-1:0] eb);
        exp_t e;
        e.gt   = (ea > eb);
        e.eq   = (ea == eb);
        e.gteq = (ea >= eb);
        e.lat  = N;
        for (int i = 0; i < int'(N); i++) begin
            if (ea[i] != eb[i]) e.lat = N - i;
        end
        sb.push_back(e);
    endtask

    task automatic send(input logic [N-1:0] va, input logic [N-1:0] vb);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        check("accept_ready", 32'(in_ready), 32'd1);
        push(va, vb);
        tick();
        in_valid = 1'b0;
    endtask

    // Called right after the accept edge; waits (bounded) for out_valid
    task automatic collect(input string tag);
        int   c;
        exp_t e;
        c = 0;
        while (!out_valid && c < int'(N) + 4) begin
            tick();
            c++;
        end
        check({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_lat"},  32'(c),    32'(e.lat));
            check({tag, "_gt"},   32'(gt),   32'(e.gt));
            check({tag, "_eq"},   32'(eq),   32'(e.eq));
            check({tag, "_gteq"}, 32'(gteq), 32'(e.gteq));
        end
        check({tag, "_inv"},   32'(gteq), 32'(gt | eq));
        check({tag, "_inrdy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        check({tag, "_ov_after"}, 32'(out_valid), 32'd0);
        check({tag, "_ir_after"}, 32'(in_ready),  32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic sgt, seq, sgteq;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_results",   32'({gteq, gt, eq}), 32'd0);

        // MSB differs: one-cycle scan
        send(8'h80, 8'h7F);
        collect("t1");
        handshake("t1");

        // Equal operands: full N-cycle scan
        send(8'h05, 8'h05);
        collect("t2");
        handshake("t2");

        // a < b at LSB; out_ready high throughout scan has no effect
        out_ready = 1'b1;
        send(8'h02, 8'h03);
        collect("t3");
        tick();
        check("t3_ov_after", 32'(out_valid), 32'd0);
        check("t3_ir_after", 32'(in_ready),  32'd1);
        out_ready = 1'b0;

        // Backpressure with toggling operands and in_valid while busy
        send(8'h9A, 8'h9C);
        collect("t4");
        sgt = gt; seq = eq; sgteq = gteq;
        for (int i = 0; i < 5; i++) begin
            a        = N'($urandom);
            b        = N'($urandom);
            in_valid = 1'b1;
            tick();
            check("t4_hold_ov",  32'(out_valid), 32'd1);
            check("t4_hold_ir",  32'(in_ready),  32'd0);
            check("t4_hold_res", 32'({gteq, gt, eq}), 32'({sgteq, sgt, seq}));
        end
        in_valid = 1'b0;
        handshake("t4");
        tick();
        check("t4_single", 32'(out_valid), 32'd0);

        // Reset in the middle of a scan discards the partial operation
        send(8'h01, 8'h00);
        tick();
        tick();
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ov", 32'(out_valid), 32'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_rel_ir",  32'(in_ready),  32'd1);
        check("t5_rel_ov",  32'(out_valid), 32'd0);
        check("t5_rel_res", 32'({gteq, gt, eq}), 32'd0);
        send(8'hFF, 8'hFF);
        collect("t5");
        handshake("t5");

        // Back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        a         = 8'hC0;
        b         = 8'hC0;
        in_valid  = 1'b1;
        push(8'hC0, 8'hC0);
        tick();
        a = 8'h40;
        b = 8'h80;
        collect("t6a");
        tick();
        check("t6_gap_ir", 32'(in_ready),  32'd1);
        check("t6_gap_ov", 32'(out_valid), 32'd0);
        push(8'h40, 8'h80);
        tick();
        check("t6_busy_ir", 32'(in_ready), 32'd0);
        collect("t6b");
        in_valid = 1'b0;
        tick();
        check("t6_end_ov", 32'(out_valid), 32'd0);
        check("t6_end_ir", 32'(in_ready),  32'd1);
        out_ready = 1'b0;

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
